// File: rtl/rmt_egress_pkt_fifo_if.sv
// AXI-Stream style bundle carried in and out of the egress packet FIFO.
// The master modport drives the beat; the slave modport returns tready.
interface rmt_egress_pkt_fifo_if #(
  parameter int DW = 512,
  parameter int UW = 128
) ();
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [UW-1:0]   tuser;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  modport master (
    output tdata, tkeep, tuser,
    output tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tuser,
    input  tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/rmt_egress_pkt_fifo.sv
// Store-and-forward egress packet FIFO behind the RMT pipeline.
// Packets are released only once complete; packets that do not fit are dropped whole.
module rmt_egress_pkt_fifo #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int DEPTH_LOG2           = 4,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                  clk,
  input  logic                  areset,
  rmt_egress_pkt_fifo_if.slave  s_axis,
  rmt_egress_pkt_fifo_if.master m_axis,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [DEPTH_LOG2:0]   fifo_level
);

  localparam int DW    = C_S_AXIS_DATA_WIDTH;
  localparam int KW    = DW / 8;
  localparam int UW    = C_S_AXIS_TUSER_WIDTH;
  localparam int EW    = DW + KW + UW + 1;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DROP
  } wr_state_e;

  logic [EW-1:0] mem [DEPTH];

  wr_state_e      state_q, state_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  commit_q, commit_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] pkt_q, pkt_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [EW-1:0]  out_q, out_d;
  logic           out_vld_q, out_vld_d;

  logic [EW-1:0]  in_beat;
  logic [PW-1:0]  level;
  logic           space;
  logic           we;
  logic           load;

  assign s_axis.tready = 1'b1;
  assign in_beat = {s_axis.tdata, s_axis.tkeep,
                    s_axis.tuser, s_axis.tlast};

  // Space uses the registered rd_ptr, so a same-cycle pop frees nothing.
  assign level = wr_ptr_q - rd_ptr_q;
  assign space = ~level[DEPTH_LOG2];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    commit_d = commit_q;
    pkt_d    = pkt_q;
    drop_d   = drop_q;
    we       = 1'b0;
    if (s_axis.tvalid) begin
      case (state_q)
        IDLE, WRITE: begin
          if (space) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (s_axis.tlast) begin
              commit_d = wr_ptr_q + PW'(1);
              pkt_d    = pkt_q + CNT_WIDTH'(1);
              state_d  = IDLE;
            end else begin
              state_d = WRITE;
            end
          end else begin
            wr_ptr_d = commit_q;
            if (s_axis.tlast) begin
              drop_d  = drop_q + CNT_WIDTH'(1);
              state_d = IDLE;
            end else begin
              state_d = DROP;
            end
          end
        end
        DROP: begin
          if (s_axis.tlast) begin
            drop_d  = drop_q + CNT_WIDTH'(1);
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    out_d     = out_q;
    out_vld_d = out_vld_q;
    load      = (rd_ptr_q != commit_q) &&
                (!out_vld_q || m_axis.tready);
    rd_ptr_d  = rd_ptr_q + PW'(load);
    if (load) begin
      out_d     = mem[rd_ptr_q[DEPTH_LOG2-1:0]];
      out_vld_d = 1'b1;
    end else if (m_axis.tready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= in_beat;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      commit_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_q     <= '0;
      drop_q    <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      commit_q  <= commit_d;
      rd_ptr_q  <= rd_ptr_d;
      pkt_q     <= pkt_d;
      drop_q    <= drop_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign {m_axis.tdata, m_axis.tkeep,
          m_axis.tuser, m_axis.tlast} = out_q;
  assign m_axis.tvalid = out_vld_q;
  assign pkt_cnt       = pkt_q;
  assign drop_cnt      = drop_q;
  assign fifo_level    = level;

endmodule
